// File: rtl/jt51_timer_pkg.sv
// Shared types and constants for the jt51 interval timer bank.
// The optional readback port is controlled by JT51_TIMER_READBACK_EN.
package jt51_timer_pkg;

  localparam int TIMER_PW = 4;

  typedef struct packed {
    logic load;
    logic oneshot;
    logic clr_flag;
    logic irq_en;
  } timer_ctrl_t;

endpackage

// File: rtl/jt51_timer_ch.sv
// One up-counting timer channel: prescaler, load edge detect, one-shot stop, flag and overflow.
// With JT51_TIMER_READBACK_EN defined the live counter is exported on cnt_rd.
module jt51_timer_ch
  import jt51_timer_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CW-1:0]       start_value,
  input  logic [TIMER_PW-1:0] prescale,
  input  timer_ctrl_t         ctrl,
  output logic                flag,
  output logic                overflow,
  output logic                irq
`ifdef JT51_TIMER_READBACK_EN
  ,
  output logic [CW-1:0]       cnt_rd
`endif
);

  logic [CW-1:0]       cnt;
  logic [TIMER_PW-1:0] pre;
  logic                last_load;
  logic                done;
  logic                rise;
  logic                ovf_evt;

  always_comb begin
    rise    = ctrl.load & ~last_load;
    // A reload on the same tick suppresses any wrap the counter would have made.
    ovf_evt = tick & ~rise & last_load & ~done & (pre == prescale) & (&cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      pre       <= '0;
      last_load <= 1'b0;
      done      <= 1'b0;
    end else if (tick) begin
      last_load <= ctrl.load;
      if (rise) begin
        cnt  <= start_value;
        pre  <= '0;
        done <= 1'b0;
      end else if (last_load & ~done) begin
        if (pre == prescale) begin
          pre <= '0;
          if (&cnt) begin
            cnt  <= start_value;
            done <= ctrl.oneshot;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  // Flag and pulse run on every clk so a clear works even while cen is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_evt;
      if (ctrl.clr_flag)
        flag <= 1'b0;
      else if (ovf_evt)
        flag <= 1'b1;
    end
  end

  assign irq = flag & ctrl.irq_en;

`ifdef JT51_TIMER_READBACK_EN
  assign cnt_rd = cnt;
`endif

endmodule

// File: rtl/jt51_timer_bank.sv
// Bank of NT interval timers: slices the packed buses per channel and combines the IRQs.
// Port cnt_rd exists only when JT51_TIMER_READBACK_EN is defined.
module jt51_timer_bank
  import jt51_timer_pkg::*;
#(
  parameter int NT = 2,
  parameter int CW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   zero,
  input  logic [NT*CW-1:0]       start_value,
  input  logic [NT-1:0]          load,
  input  logic [NT-1:0]          oneshot,
  input  logic [NT*TIMER_PW-1:0] prescale,
  input  logic [NT-1:0]          clr_flag,
  input  logic [NT-1:0]          irq_en,
  output logic [NT-1:0]          flag,
  output logic [NT-1:0]          overflow,
  output logic                   irq_n
`ifdef JT51_TIMER_READBACK_EN
  ,
  output logic [NT*CW-1:0]       cnt_rd
`endif
);

  logic          tick;
  logic [NT-1:0] irq;

  assign tick  = cen & zero;
  assign irq_n = ~|irq;

  for (genvar i = 0; i < NT; i++) begin : g_ch
    timer_ctrl_t ctrl;

    assign ctrl = '{load: load[i], oneshot: oneshot[i], clr_flag: clr_flag[i], irq_en: irq_en[i]};

    jt51_timer_ch #(.CW(CW)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .start_value(start_value[i*CW +: CW]),
      .prescale   (prescale[i*TIMER_PW +: TIMER_PW]),
      .ctrl       (ctrl),
      .flag       (flag[i]),
      .overflow   (overflow[i]),
      .irq        (irq[i])
`ifdef JT51_TIMER_READBACK_EN
      ,
      .cnt_rd     (cnt_rd[i*CW +: CW])
`endif
    );
  end

endmodule
